// File: rtl/riscv_biu_arbiter.sv
// Two-requester BIU arbiter: grants the D or I memory controller per transaction and holds
// ownership across bursts, locked sequences and outstanding data phases.
module riscv_biu_arbiter #(
  parameter int XLEN      = 32,
  parameter int PLEN      = 32,
  parameter int PRIORITY  = 0,
  parameter int MAX_OUTST = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  input  logic            d_stb_i,
  output logic            d_stb_ack_o,
  output logic            d_d_ack_o,
  input  logic [PLEN-1:0] d_adri_i,
  output logic [PLEN-1:0] d_adro_o,
  input  logic [2:0]      d_size_i,
  input  logic [2:0]      d_type_i,
  input  logic            d_we_i,
  input  logic            d_lock_i,
  input  logic [2:0]      d_prot_i,
  input  logic [XLEN-1:0] d_d_i,
  output logic [XLEN-1:0] d_q_o,
  output logic            d_ack_o,
  output logic            d_err_o,

  input  logic            i_stb_i,
  output logic            i_stb_ack_o,
  output logic            i_d_ack_o,
  input  logic [PLEN-1:0] i_adri_i,
  output logic [PLEN-1:0] i_adro_o,
  input  logic [2:0]      i_size_i,
  input  logic [2:0]      i_type_i,
  input  logic            i_we_i,
  input  logic            i_lock_i,
  input  logic [2:0]      i_prot_i,
  input  logic [XLEN-1:0] i_d_i,
  output logic [XLEN-1:0] i_q_o,
  output logic            i_ack_o,
  output logic            i_err_o,

  output logic            biu_stb_o,
  input  logic            biu_stb_ack_i,
  input  logic            biu_d_ack_i,
  output logic [PLEN-1:0] biu_adri_o,
  input  logic [PLEN-1:0] biu_adro_i,
  output logic [2:0]      biu_size_o,
  output logic [2:0]      biu_type_o,
  output logic            biu_we_o,
  output logic            biu_lock_o,
  output logic [2:0]      biu_prot_o,
  output logic [XLEN-1:0] biu_d_o,
  input  logic [XLEN-1:0] biu_q_i,
  input  logic            biu_ack_i,
  input  logic            biu_err_i
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWN_D = 2'd1, ST_OWN_I = 2'd2} state_t;

  state_t          r_state;
  logic [3:0]      r_beat;
  logic [OW-1:0]   r_outst;
  logic            r_last_d;

  logic            w_pick_d, w_own_d, w_own_i, w_full, w_stb, w_we, w_lock;
  logic            w_accept, w_done, w_release;
  logic [PLEN-1:0] w_adri;
  logic [2:0]      w_size, w_type, w_prot;
  logic [XLEN-1:0] w_d;
  logic [3:0]      w_beat_nxt;
  logic [OW-1:0]   w_outst_nxt;

  // INCR of unspecified length is tracked as a 4-beat burst
  function automatic logic [3:0] burst_last(input logic [2:0] btype);
    case (btype)
      3'd0:             return 4'd0;
      3'd1, 3'd2, 3'd3: return 4'd3;
      3'd4, 3'd5:       return 4'd7;
      3'd6, 3'd7:       return 4'd15;
      default:          return 4'd0;
    endcase
  endfunction

  always_comb begin
    if (PRIORITY == 0) w_pick_d = d_stb_i;
    else               w_pick_d = d_stb_i & (~i_stb_i | ~r_last_d);
  end

  assign w_own_d = (r_state == ST_OWN_D) | ((r_state == ST_IDLE) & w_pick_d);
  assign w_own_i = (r_state == ST_OWN_I) | ((r_state == ST_IDLE) & ~w_pick_d & i_stb_i);
  assign w_full  = (r_outst == OW'(MAX_OUTST));

  always_comb begin
    w_stb = 1'b0; w_adri = {PLEN{1'b0}}; w_size = 3'd0; w_type = 3'd0;
    w_we = 1'b0; w_lock = 1'b0; w_prot = 3'd0; w_d = {XLEN{1'b0}};
    if (w_own_d) begin
      w_stb = d_stb_i & ~w_full; w_adri = d_adri_i; w_size = d_size_i; w_type = d_type_i;
      w_we = d_we_i; w_lock = d_lock_i; w_prot = d_prot_i; w_d = d_d_i;
    end else if (w_own_i) begin
      w_stb = i_stb_i & ~w_full; w_adri = i_adri_i; w_size = i_size_i; w_type = i_type_i;
      w_we = i_we_i; w_lock = i_lock_i; w_prot = i_prot_i; w_d = i_d_i;
    end else begin
      w_stb = 1'b0;
    end
  end

  assign w_accept = w_stb & biu_stb_ack_i;
  assign w_done   = biu_ack_i | biu_err_i;

  always_comb begin
    if (biu_err_i)              w_beat_nxt = 4'd0;
    else if (!w_accept)         w_beat_nxt = r_beat;
    else if (r_beat == 4'd0)    w_beat_nxt = burst_last(w_type);
    else                        w_beat_nxt = r_beat - 4'd1;
  end

  always_comb begin
    w_outst_nxt = r_outst;
    if (w_accept && !w_done)                             w_outst_nxt = r_outst + OW'(1);
    else if (!w_accept && w_done && r_outst != {OW{1'b0}}) w_outst_nxt = r_outst - OW'(1);
    else                                                 w_outst_nxt = r_outst;
  end

  // Release looks at next-cycle counters so a beat accepted on the release edge keeps ownership
  assign w_release = (w_beat_nxt == 4'd0) && (w_outst_nxt == {OW{1'b0}}) && !w_lock;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_beat   <= 4'd0;
      r_outst  <= {OW{1'b0}};
      r_last_d <= 1'b0;
    end else begin
      r_beat  <= w_beat_nxt;
      r_outst <= w_outst_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_own_d)      r_state <= ST_OWN_D;
          else if (w_own_i) r_state <= ST_OWN_I;
          else              r_state <= ST_IDLE;
        end
        ST_OWN_D: if (w_release) begin r_state <= ST_IDLE; r_last_d <= 1'b1; end
        ST_OWN_I: if (w_release) begin r_state <= ST_IDLE; r_last_d <= 1'b0; end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // All outputs are forced low while reset is asserted, including the combinational grant path
  assign biu_stb_o  = rst_ni & w_stb;
  assign biu_adri_o = {PLEN{rst_ni}} & w_adri;
  assign biu_size_o = {3{rst_ni}} & w_size;
  assign biu_type_o = {3{rst_ni}} & w_type;
  assign biu_we_o   = rst_ni & w_we;
  assign biu_lock_o = rst_ni & w_lock;
  assign biu_prot_o = {3{rst_ni}} & w_prot;
  assign biu_d_o    = {XLEN{rst_ni}} & w_d;

  assign d_stb_ack_o = rst_ni & w_own_d & w_stb & biu_stb_ack_i;
  assign d_d_ack_o   = rst_ni & w_own_d & biu_d_ack_i;
  assign d_ack_o     = rst_ni & w_own_d & biu_ack_i;
  assign d_err_o     = rst_ni & w_own_d & biu_err_i;
  assign d_adro_o    = {PLEN{rst_ni}} & biu_adro_i;
  assign d_q_o       = {XLEN{rst_ni}} & biu_q_i;

  assign i_stb_ack_o = rst_ni & w_own_i & w_stb & biu_stb_ack_i;
  assign i_d_ack_o   = rst_ni & w_own_i & biu_d_ack_i;
  assign i_ack_o     = rst_ni & w_own_i & biu_ack_i;
  assign i_err_o     = rst_ni & w_own_i & biu_err_i;
  assign i_adro_o    = {PLEN{rst_ni}} & biu_adro_i;
  assign i_q_o       = {XLEN{rst_ni}} & biu_q_i;

endmodule

// File: tb/tb_riscv_biu_arbiter.sv
// Directed table-driven bench for riscv_biu_arbiter: fixed-priority instance checked per cycle,
// round-robin instance checked in a hand-written tie sequence.
module tb_riscv_biu_arbiter;

  localparam int SGL = 0, INCR4 = 3, INCR8 = 5;
  localparam int ON = 0, OD = 1, OI = 2;

  logic clk = 1'b0, rst_ni;
  always #5 clk = ~clk;

  logic d_stb_i, d_we_i, d_lock_i, i_stb_i, i_we_i, i_lock_i;
  logic [31:0] d_adri_i, i_adri_i, d_d_i, i_d_i, biu_adro_i, biu_q_i;
  logic [2:0] d_size_i, d_type_i, d_prot_i, i_size_i, i_type_i, i_prot_i;
  logic biu_stb_ack_i, biu_d_ack_i, biu_ack_i, biu_err_i;

  logic d_stb_ack_o, d_d_ack_o, d_ack_o, d_err_o, i_stb_ack_o, i_d_ack_o, i_ack_o, i_err_o;
  logic [31:0] d_adro_o, d_q_o, i_adro_o, i_q_o, biu_adri_o, biu_d_o;
  logic biu_stb_o, biu_we_o, biu_lock_o;
  logic [2:0] biu_size_o, biu_type_o, biu_prot_o;

  logic d_stb_ack_1, d_d_ack_1, d_ack_1, d_err_1, i_stb_ack_1, i_d_ack_1, i_ack_1, i_err_1;
  logic [31:0] d_adro_1, d_q_1, i_adro_1, i_q_1, biu_adri_1, biu_d_1;
  logic biu_stb_1, biu_we_1, biu_lock_1;
  logic [2:0] biu_size_1, biu_type_1, biu_prot_1;

  riscv_biu_arbiter #(.XLEN(32), .PLEN(32), .PRIORITY(0), .MAX_OUTST(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .d_stb_i(d_stb_i), .d_stb_ack_o(d_stb_ack_o), .d_d_ack_o(d_d_ack_o), .d_adri_i(d_adri_i),
    .d_adro_o(d_adro_o), .d_size_i(d_size_i), .d_type_i(d_type_i), .d_we_i(d_we_i),
    .d_lock_i(d_lock_i), .d_prot_i(d_prot_i), .d_d_i(d_d_i), .d_q_o(d_q_o), .d_ack_o(d_ack_o),
    .d_err_o(d_err_o),
    .i_stb_i(i_stb_i), .i_stb_ack_o(i_stb_ack_o), .i_d_ack_o(i_d_ack_o), .i_adri_i(i_adri_i),
    .i_adro_o(i_adro_o), .i_size_i(i_size_i), .i_type_i(i_type_i), .i_we_i(i_we_i),
    .i_lock_i(i_lock_i), .i_prot_i(i_prot_i), .i_d_i(i_d_i), .i_q_o(i_q_o), .i_ack_o(i_ack_o),
    .i_err_o(i_err_o),
    .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i),
    .biu_adri_o(biu_adri_o), .biu_adro_i(biu_adro_i), .biu_size_o(biu_size_o),
    .biu_type_o(biu_type_o), .biu_we_o(biu_we_o), .biu_lock_o(biu_lock_o),
    .biu_prot_o(biu_prot_o), .biu_d_o(biu_d_o), .biu_q_i(biu_q_i), .biu_ack_i(biu_ack_i),
    .biu_err_i(biu_err_i)
  );

  riscv_biu_arbiter #(.XLEN(32), .PLEN(32), .PRIORITY(1), .MAX_OUTST(2)) dut_rr (
    .clk_i(clk), .rst_ni(rst_ni),
    .d_stb_i(d_stb_i), .d_stb_ack_o(d_stb_ack_1), .d_d_ack_o(d_d_ack_1), .d_adri_i(d_adri_i),
    .d_adro_o(d_adro_1), .d_size_i(d_size_i), .d_type_i(d_type_i), .d_we_i(d_we_i),
    .d_lock_i(d_lock_i), .d_prot_i(d_prot_i), .d_d_i(d_d_i), .d_q_o(d_q_1), .d_ack_o(d_ack_1),
    .d_err_o(d_err_1),
    .i_stb_i(i_stb_i), .i_stb_ack_o(i_stb_ack_1), .i_d_ack_o(i_d_ack_1), .i_adri_i(i_adri_i),
    .i_adro_o(i_adro_1), .i_size_i(i_size_i), .i_type_i(i_type_i), .i_we_i(i_we_i),
    .i_lock_i(i_lock_i), .i_prot_i(i_prot_i), .i_d_i(i_d_i), .i_q_o(i_q_1), .i_ack_o(i_ack_1),
    .i_err_o(i_err_1),
    .biu_stb_o(biu_stb_1), .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i),
    .biu_adri_o(biu_adri_1), .biu_adro_i(biu_adro_i), .biu_size_o(biu_size_1),
    .biu_type_o(biu_type_1), .biu_we_o(biu_we_1), .biu_lock_o(biu_lock_1),
    .biu_prot_o(biu_prot_1), .biu_d_o(biu_d_1), .biu_q_i(biu_q_i), .biu_ack_i(biu_ack_i),
    .biu_err_i(biu_err_i)
  );

  logic [211:0] all_out;
  assign all_out = {biu_stb_o, biu_adri_o, biu_size_o, biu_type_o, biu_we_o, biu_lock_o,
                    biu_prot_o, biu_d_o, d_stb_ack_o, d_d_ack_o, d_adro_o, d_q_o, d_ack_o,
                    d_err_o, i_stb_ack_o, i_d_ack_o, i_adro_o, i_q_o, i_ack_o, i_err_o};

  typedef struct {
    logic ds, dl; logic [2:0] dt; logic is_, il; logic [2:0] it; logic sa, ak, er;
    logic [1:0] own; logic stb, lk, dsa, isa, dak, iak, der, ier;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0, n_errors = 0;

  task automatic add(input int ds, dl, dt, is_, il, it, sa, ak, er,
                     input int own, stb, lk, dsa, isa, dak, iak, der, ier);
    vec_t v;
    v.ds = 1'(ds); v.dl = 1'(dl); v.dt = 3'(dt); v.is_ = 1'(is_); v.il = 1'(il); v.it = 3'(it);
    v.sa = 1'(sa); v.ak = 1'(ak); v.er = 1'(er); v.own = 2'(own); v.stb = 1'(stb); v.lk = 1'(lk);
    v.dsa = 1'(dsa); v.isa = 1'(isa); v.dak = 1'(dak); v.iak = 1'(iak); v.der = 1'(der);
    v.ier = 1'(ier);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic ds, dl, input logic [2:0] dt, input logic is_, il,
                       input logic [2:0] it, input logic sa, ak, er);
    d_stb_i = ds; d_lock_i = dl; d_type_i = dt; i_stb_i = is_; i_lock_i = il; i_type_i = it;
    biu_stb_ack_i = sa; biu_ack_i = ak; biu_err_i = er; biu_d_ack_i = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_adr;
    d_adri_i = 32'h0000_0100; i_adri_i = 32'h0000_2000; d_d_i = 32'hD0D0_D0D0;
    i_d_i = 32'h1111_2222; biu_adro_i = 32'h0000_0ABC; biu_q_i = 32'hCAFE_F00D;
    d_size_i = 3'd2; i_size_i = 3'd1; d_we_i = 1'b1; i_we_i = 1'b0;
    d_prot_i = 3'd1; i_prot_i = 3'd4;

    // ds dl dt  is il it  sa ak er | own stb lk dsa isa dak iak der ier
    add(1,0,SGL, 0,0,SGL, 1,0,0, OD,1,0, 1,0,0,0,0,0);   // D single read
    add(0,0,SGL, 0,0,SGL, 0,1,0, OD,0,0, 0,0,1,0,0,0);
    add(0,0,SGL, 0,0,SGL, 0,0,0, ON,0,0, 0,0,0,0,0,0);
    add(1,0,SGL, 1,0,SGL, 1,0,0, OD,1,0, 1,0,0,0,0,0);   // tie, fixed priority
    add(0,0,SGL, 1,0,SGL, 0,1,0, OD,0,0, 0,0,1,0,0,0);
    add(0,0,SGL, 1,0,SGL, 1,0,0, OI,1,0, 0,1,0,0,0,0);
    add(0,0,SGL, 0,0,SGL, 0,1,0, OI,0,0, 0,0,0,1,0,0);
    add(0,0,SGL, 0,0,SGL, 0,0,0, ON,0,0, 0,0,0,0,0,0);
    add(0,0,SGL, 1,0,INCR8, 1,0,0, OI,1,0, 0,1,0,0,0,0); // I INCR8, D blocked
    add(0,0,SGL, 1,0,INCR8, 1,1,0, OI,1,0, 0,1,0,1,0,0);
    add(1,0,SGL, 1,0,INCR8, 1,1,0, OI,1,0, 0,1,0,1,0,0);
    add(1,0,SGL, 0,0,INCR8, 1,1,0, OI,0,0, 0,0,0,1,0,0);
    add(1,0,SGL, 1,0,INCR8, 1,0,0, OI,1,0, 0,1,0,0,0,0);
    for (int k = 0; k < 4; k++) add(1,0,SGL, 1,0,INCR8, 1,1,0, OI,1,0, 0,1,0,1,0,0);
    add(1,0,SGL, 0,0,INCR8, 0,1,0, OI,0,0, 0,0,0,1,0,0);
    add(1,0,SGL, 0,0,SGL, 1,0,0, OD,1,0, 1,0,0,0,0,0);
    add(0,0,SGL, 0,0,SGL, 0,1,0, OD,0,0, 0,0,1,0,0,0);
    add(1,0,INCR4, 0,0,SGL, 1,0,0, OD,1,0, 1,0,0,0,0,0); // outstanding limit
    add(1,0,INCR4, 0,0,SGL, 1,0,0, OD,1,0, 1,0,0,0,0,0);
    add(1,0,INCR4, 0,0,SGL, 1,0,0, OD,0,0, 0,0,0,0,0,0);
    add(1,0,INCR4, 0,0,SGL, 1,0,0, OD,0,0, 0,0,0,0,0,0);
    add(1,0,INCR4, 0,0,SGL, 1,1,0, OD,0,0, 0,0,1,0,0,0);
    add(1,0,INCR4, 0,0,SGL, 1,0,0, OD,1,0, 1,0,0,0,0,0);
    add(1,0,INCR4, 0,0,SGL, 1,1,0, OD,0,0, 0,0,1,0,0,0);
    add(1,0,INCR4, 0,0,SGL, 1,0,0, OD,1,0, 1,0,0,0,0,0);
    add(0,0,SGL, 0,0,SGL, 0,1,0, OD,0,0, 0,0,1,0,0,0);
    add(0,0,SGL, 0,0,SGL, 0,1,0, OD,0,0, 0,0,1,0,0,0);
    add(1,1,SGL, 1,0,SGL, 1,0,0, OD,1,1, 1,0,0,0,0,0);   // locked pair
    add(0,1,SGL, 1,0,SGL, 0,1,0, OD,0,1, 0,0,1,0,0,0);
    add(1,1,SGL, 1,0,SGL, 1,0,0, OD,1,1, 1,0,0,0,0,0);
    add(0,1,SGL, 1,0,SGL, 0,1,0, OD,0,1, 0,0,1,0,0,0);
    add(0,1,SGL, 1,0,SGL, 1,0,0, OD,0,1, 0,0,0,0,0,0);
    add(0,0,SGL, 1,0,SGL, 1,0,0, OD,0,0, 0,0,0,0,0,0);
    add(0,0,SGL, 1,0,SGL, 1,0,0, OI,1,0, 0,1,0,0,0,0);
    add(0,0,SGL, 0,0,SGL, 0,1,0, OI,0,0, 0,0,0,1,0,0);
    add(1,0,INCR4, 0,0,SGL, 1,0,0, OD,1,0, 1,0,0,0,0,0); // error mid-burst
    add(1,0,INCR4, 0,0,SGL, 1,0,0, OD,1,0, 1,0,0,0,0,0);
    add(0,0,INCR4, 1,0,SGL, 1,0,1, OD,0,0, 0,0,0,0,1,0);
    add(0,0,INCR4, 1,0,SGL, 1,1,0, OD,0,0, 0,0,1,0,0,0);
    add(0,0,SGL, 1,0,INCR4, 1,0,0, OI,1,0, 0,1,0,0,0,0);

    rst_ni = 1'b0;
    drive(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    #12;
    check("reset_outputs", 64'(|all_out), 64'd0);
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;

    foreach (vecs[n]) begin
      @(posedge clk); #1;
      drive(vecs[n].ds, vecs[n].dl, vecs[n].dt, vecs[n].is_, vecs[n].il, vecs[n].it,
            vecs[n].sa, vecs[n].ak, vecs[n].er);
      @(negedge clk);
      case (vecs[n].own)
        2'd1:    exp_adr = 32'h0000_0100;
        2'd2:    exp_adr = 32'h0000_2000;
        default: exp_adr = 32'h0000_0000;
      endcase
      check($sformatf("vec%0d", n),
            64'({biu_adri_o, biu_stb_o, biu_lock_o, d_stb_ack_o, i_stb_ack_o, d_ack_o, i_ack_o,
                 d_err_o, i_err_o}),
            64'({exp_adr, vecs[n].stb, vecs[n].lk, vecs[n].dsa, vecs[n].isa, vecs[n].dak,
                 vecs[n].iak, vecs[n].der, vecs[n].ier}));
    end

    // asynchronous reset in the middle of the I burst
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    #1 check("pre_reset", 64'({biu_stb_o, biu_adri_o}), 64'({1'b1, 32'h0000_2000}));
    #1 rst_ni = 1'b0;
    #1 check("mid_reset_outputs", 64'(|all_out), 64'd0);
    check("mid_reset_rr_stb", 64'(biu_stb_1), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // tie after reset: both pick D (round-robin last owner is I)
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    biu_d_ack_i = 1'b1;
    @(negedge clk);
    check("h1_fixed", 64'({biu_adri_o, d_stb_ack_o, d_d_ack_o, i_d_ack_o, biu_we_o}),
          64'({32'h0000_0100, 1'b1, 1'b1, 1'b0, 1'b1}));
    check("h1_wdata", 64'(biu_d_o), 64'(32'hD0D0_D0D0));
    check("h1_rr", 64'({biu_adri_1, d_stb_ack_1}), 64'({32'h0000_0100, 1'b1}));

    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("h2_ack", 64'({d_ack_o, i_ack_o, d_q_o}), 64'({1'b1, 1'b0, 32'hCAFE_F00D}));
    check("h2_rr_ack", 64'({d_ack_1, i_ack_1}), 64'({1'b1, 1'b0}));

    // tie with last owner D: fixed priority keeps D, round-robin gives I
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("h3_fixed", 64'({biu_adri_o, d_stb_ack_o, i_stb_ack_o}),
          64'({32'h0000_0100, 1'b1, 1'b0}));
    check("h3_rr", 64'({biu_adri_1, d_stb_ack_1, i_stb_ack_1}),
          64'({32'h0000_2000, 1'b0, 1'b1}));

    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
